// File: rtl/fetch_pc.sv
// Fetch program counter: sequential advance, memory handshake wait, and
// jump/branch redirect with stall-time capture of the redirect target.
module fetch_pc #(
    parameter int                 WIDTH        = 16,
    parameter int                 ALIGN        = 1,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_offset,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             imem_ready,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic             imem_req,
    output logic             flush,
    output logic             align_err
);

    localparam logic [WIDTH-1:0] STEP     = WIDTH'(1) << ALIGN;
    localparam logic [WIDTH-1:0] LOW_MASK = STEP - WIDTH'(1);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, REDIRECT} state_t;

    state_t           state;
    logic             pend_valid;
    logic [WIDTH-1:0] pend_target;
    logic             pend_err;

    logic             redirect_live;
    logic [WIDTH-1:0] raw_target;
    logic [WIDTH-1:0] live_target;
    logic             live_err;

    assign pc_plus       = pc + STEP;
    assign redirect_live = jump | branch_taken;
    assign raw_target    = jump ? jump_target : (pc + branch_offset);
    assign live_target   = raw_target & ~LOW_MASK;
    assign live_err      = |(raw_target & LOW_MASK);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_VECTOR;
            imem_req    <= 1'b0;
            flush       <= 1'b0;
            align_err   <= 1'b0;
            pend_valid  <= 1'b0;
            pend_target <= '0;
            pend_err    <= 1'b0;
        end else begin
            flush     <= 1'b0;
            align_err <= 1'b0;
            case (state)
                IDLE, REDIRECT: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH, WAIT: begin
                    if (stall) begin
                        // Latest redirect seen while stalled wins when the stall drops
                        if (redirect_live) begin
                            pend_valid  <= 1'b1;
                            pend_target <= live_target;
                            pend_err    <= live_err;
                        end
                    end else if (redirect_live || pend_valid) begin
                        pc         <= redirect_live ? live_target : pend_target;
                        align_err  <= redirect_live ? live_err : pend_err;
                        flush      <= 1'b1;
                        imem_req   <= 1'b0;
                        pend_valid <= 1'b0;
                        state      <= REDIRECT;
                    end else if (state == FETCH) begin
                        if (imem_ready)
                            pc <= pc_plus;
                        else
                            state <= WAIT;
                    end else if (imem_ready) begin
                        state <= FETCH;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc.sv
// Scoreboard bench for fetch_pc: directed stimulus pushes expected fetch
// addresses and redirect events; a negedge monitor pops and compares them.
module tb_fetch_pc;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [15:0] jump_target;
    logic        imem_ready;
    logic [15:0] pc;
    logic [15:0] pc_plus;
    logic        imem_req;
    logic        flush;
    logic        align_err;

    typedef struct {
        logic [15:0] pc;
        logic        err;
    } redir_t;

    logic [15:0] req_q[$];
    redir_t      flush_q[$];

    int checks = 0;
    int errors = 0;

    fetch_pc #(.WIDTH(16), .ALIGN(1), .RESET_VECTOR(16'h0000)) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .branch_taken(branch_taken),
        .branch_offset(branch_offset),
        .jump(jump),
        .jump_target(jump_target),
        .imem_ready(imem_ready),
        .pc(pc),
        .pc_plus(pc_plus),
        .imem_req(imem_req),
        .flush(flush),
        .align_err(align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic [15:0] a, input int n);
        for (int i = 0; i < n; i++) req_q.push_back(a);
    endtask

    task automatic push_flush(input logic [15:0] a, input logic e);
        redir_t r;
        r.pc  = a;
        r.err = e;
        flush_q.push_back(r);
    endtask

    // Monitor: flush cycles are redirect events, otherwise imem_req marks a fetch address.
    always @(negedge clk) begin
        if (!reset) begin
            if (flush || align_err) begin
                if (flush_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_redirect: got pc %h flush %b align_err %b expected none", pc, flush, align_err);
                end else begin
                    redir_t e;
                    e = flush_q.pop_front();
                    check("redirect_pc", 32'(pc), 32'(e.pc));
                    check("align_err", 32'(align_err), 32'(e.err));
                    check("flush", 32'(flush), 32'd1);
                    check("flush_imem_req", 32'(imem_req), 32'd0);
                end
            end else if (imem_req) begin
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_fetch: got pc %h expected no request", pc);
                end else begin
                    logic [15:0] exp;
                    exp = req_q.pop_front();
                    check("fetch_pc", 32'(pc), 32'(exp));
                    check("pc_plus", 32'(pc_plus), 32'(16'(exp + 16'd2)));
                end
            end
        end
    end

    initial begin
        #5000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_offset = '0;
        jump = 1'b0; jump_target = '0; imem_ready = 1'b1;
        #1 reset = 1'b1;
        #1;
        check("reset_pc", 32'(pc), 32'h0);
        check("reset_imem_req", 32'(imem_req), 32'd0);
        check("reset_flush", 32'(flush), 32'd0);
        check("reset_align_err", 32'(align_err), 32'd0);

        @(posedge clk); #1 reset = 1'b0;
        for (int a = 0; a <= 16; a += 2) push_req(16'(a), 1);
        #2 check("idle_imem_req", 32'(imem_req), 32'd0);
        step(1);
        step(8);

        // pc=0x0010, backward branch to 0x0008
        branch_taken = 1'b1; branch_offset = 16'hFFF8;
        push_flush(16'h0008, 1'b0);
        step(1);
        branch_taken = 1'b0;
        push_req(16'h0008, 1);
        step(1);

        // jump beats branch, misaligned target
        jump = 1'b1; jump_target = 16'h0123; branch_taken = 1'b1; branch_offset = 16'h0004;
        push_flush(16'h0122, 1'b1);
        step(1);
        jump = 1'b0; branch_taken = 1'b0;
        push_req(16'h0122, 1);
        step(1);

        // move to 0x0020, then memory not ready for 3 cycles
        jump = 1'b1; jump_target = 16'h0020;
        push_flush(16'h0020, 1'b0);
        step(1);
        jump = 1'b0;
        push_req(16'h0020, 5);
        push_req(16'h0022, 1);
        step(1);
        imem_ready = 1'b0;
        step(3);
        imem_ready = 1'b1;
        step(2);

        // jump presented under stall is held until the stall drops
        stall = 1'b1; jump = 1'b1; jump_target = 16'h0040;
        push_req(16'h0022, 3);
        push_flush(16'h0040, 1'b0);
        push_req(16'h0040, 1);
        step(1);
        jump = 1'b0;
        step(2);
        stall = 1'b0;
        step(2);

        // pending misaligned jump overridden by a live branch as stall drops
        stall = 1'b1; jump = 1'b1; jump_target = 16'h0081;
        push_req(16'h0040, 1);
        push_flush(16'h0050, 1'b0);
        push_req(16'h0050, 1);
        push_req(16'h0052, 1);
        step(1);
        jump = 1'b0; stall = 1'b0; branch_taken = 1'b1; branch_offset = 16'h0010;
        step(1);
        branch_taken = 1'b0;
        step(2);

        // wrap past 0xFFFE, then 0x0004 + 0xFFF8
        jump = 1'b1; jump_target = 16'hFFFC;
        push_flush(16'hFFFC, 1'b0);
        push_req(16'hFFFC, 1);
        push_req(16'hFFFE, 1);
        push_req(16'h0000, 1);
        push_req(16'h0002, 1);
        push_req(16'h0004, 1);
        step(1);
        jump = 1'b0;
        step(5);
        branch_taken = 1'b1; branch_offset = 16'hFFF8;
        push_flush(16'hFFFC, 1'b0);
        push_req(16'hFFFC, 2);
        step(1);
        branch_taken = 1'b0;
        step(1);
        imem_ready = 1'b0;
        step(1);

        // asynchronous reset in the middle of WAIT
        #6 reset = 1'b1;
        #1;
        check("async_pc", 32'(pc), 32'h0);
        check("async_imem_req", 32'(imem_req), 32'd0);
        check("async_flush", 32'(flush), 32'd0);
        @(posedge clk); #1 reset = 1'b0; imem_ready = 1'b1;
        push_req(16'h0000, 1);
        push_req(16'h0002, 1);
        #2 check("restart_idle_imem_req", 32'(imem_req), 32'd0);
        step(1);
        step(1);
        #6 reset = 1'b1;
        #10;
        check("req_queue_drained", 32'(req_q.size()), 32'd0);
        check("flush_queue_drained", 32'(flush_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc.md
FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001 SHALL have parameter WIDTH, default 16: PC and address width.
REQ-002 SHALL have parameter ALIGN, default 1: log2 of instruction bytes; sequential increment is 2**ALIGN.
REQ-003 SHALL have parameter RESET_VECTOR, default 0: PC value loaded on reset.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge; the block has one clock.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port stall  input  1  hazard hold from the pipeline.
REQ-007 SHALL have port branch_taken  input  1  resolved conditional branch.
REQ-008 SHALL have port branch_offset  input  WIDTH  byte offset, already shifted left by the upstream sll stage, two's complement.
REQ-009 SHALL have port jump  input  1  unconditional redirect.
REQ-010 SHALL have port jump_target  input  WIDTH  absolute byte address.
REQ-011 SHALL have port imem_ready  input  1  instruction memory accepted the current address.
REQ-012 SHALL have port pc  output  WIDTH  current fetch address, registered.
REQ-013 SHALL have port pc_plus  output  WIDTH  pc + 2**ALIGN, combinational, modulo 2**WIDTH.
REQ-014 SHALL have port imem_req  output  1  fetch request valid.
REQ-015 SHALL have port flush  output  1  one-cycle kill of the wrong-path instruction.
REQ-016 SHALL have port align_err  output  1  one-cycle pulse for a misaligned redirect target.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, WAIT, REDIRECT, with state registered.
REQ-018 IDLE: imem_req=0; next state is FETCH unconditionally, giving one dead cycle after reset.
REQ-019 FETCH: imem_req=1; on imem_ready=1 and stall=0, pc<=next_pc; on imem_ready=0, go to WAIT with pc held.
REQ-020 WAIT: imem_req=1 and pc held; on imem_ready=1, return to FETCH without advancing pc, so the address is re-issued.
REQ-021 next_pc SHALL use priority jump > branch_taken > sequential: jump_target; else pc+branch_offset; else pc_plus.
REQ-022 All address arithmetic SHALL be WIDTH-bit modulo 2**WIDTH: 0xFFFE+2 gives 0x0000, and 0x0004+0xFFF8 gives 0xFFFC.
REQ-023 Redirect targets SHALL have their low ALIGN bits forced to zero; if any forced bit was 1, align_err SHALL pulse for exactly that cycle.
REQ-024 When a redirect (jump or branch_taken) is applied, pc SHALL load the target, the state SHALL go to REDIRECT, and flush SHALL be 1 for exactly that one following cycle.
REQ-025 REDIRECT: imem_req=0, pc held; next state FETCH.
REQ-026 The redirect SHALL be applied in FETCH or WAIT regardless of imem_ready; a pending WAIT request SHALL be abandoned.
REQ-027 stall=1 SHALL hold pc and state, keeping imem_req at its current value.
REQ-028 A redirect arriving during stall SHALL be captured in a pending target register, together with its align_err; later redirects overwrite it.
REQ-029 The pending redirect SHALL be applied on the first cycle with stall=0, taking precedence over that cycle's sequential advance, and SHALL then be cleared.
REQ-030 A live redirect input on the same cycle that stall drops SHALL override the pending one.
REQ-031 Redirect inputs SHALL be ignored in IDLE and REDIRECT.

Reset
REQ-032 On reset assertion, immediately and without clk: pc=RESET_VECTOR, state=IDLE, imem_req=0, flush=0, align_err=0, pending cleared.
REQ-033 Reset asserted mid-WAIT or mid-REDIRECT SHALL discard all in-flight state, and fetch SHALL restart from RESET_VECTOR.
REQ-034 Reset release SHALL be sampled on clk; the first FETCH cycle SHALL be the second rising edge after release.

Verification
REQ-035 Reset release with imem_ready=1 and no stall -> imem_req 0 for one cycle, then pc sequence 0x0000, 0x0002, 0x0004.
REQ-036 At pc=0x0010: branch_taken=1, branch_offset=0xFFF8 -> pc=0x0008, flush=1 for one cycle, imem_req=0 that cycle.
REQ-037 jump=1 with jump_target=0x0123 and branch_taken=1 on the same cycle -> pc=0x0122, align_err pulses once, branch ignored.
REQ-038 imem_ready low for 3 cycles at pc=0x0020 -> pc holds at 0x0020 with imem_req=1 throughout, then advances to 0x0022.
REQ-039 stall=1 while jump to 0x0040 is presented, stall held 2 more cycles -> pc unchanged while stalled, then 0x0040 with flush.
REQ-040 At pc=0xFFFE advancing -> pc wraps to 0x0000; asynchronous reset pulse mid-WAIT -> pc=0x0000 and imem_req=0 before the next edge.
